// File: rtl/tour_sched.sv
// Knight's-tour scheduler: accepts a tour command, launches the solver with a
// timeout, hands off to the command generator and counts move completions.
module tour_sched #(
  parameter int NUM_RESP = 48,
  parameter int TMO_W    = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        tour_done,
  input  logic        send_resp,
  output logic        go,
  output logic [2:0]  x_start,
  output logic [2:0]  y_start,
  output logic        start_tour,
  output logic        tour_busy,
  output logic        tour_cplt,
  output logic        tour_err,
  output logic [1:0]  state_o
);

  localparam int CNT_W = $clog2(NUM_RESP) + 1;
  localparam logic [3:0] TOUR_OP = 4'b0110;
  localparam logic [CNT_W-1:0] LAST_RESP = CNT_W'(NUM_RESP - 1);
  // Timer value one short of all-ones: the error registers as the count reaches all-ones.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE = 2'd0, SOLVE = 2'd1, START = 2'd2, RUN = 2'd3} state_e;

  // Handshakes: go, start_tour, tour_cplt and tour_err are single-cycle
  // registered pulses; cmd_rdy_UART is a level whose rising edge is the request.
  state_e            state_q, state_d;
  logic              rdy_q, rdy_prev_q;
  logic [TMO_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        x_q, x_d, y_q, y_d;
  logic              go_q, go_d, start_q, start_d, cplt_q, cplt_d, err_q, err_d;
  logic              busy_q, busy_d;
  logic              rise, is_tour, sq_ok, tmo;

  assign rise    = rdy_q & ~rdy_prev_q;
  assign is_tour = (cmd_UART[15:12] == TOUR_OP);
  assign sq_ok   = ~cmd_UART[7] & ~cmd_UART[3];
  assign tmo     = (timer_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    go_d    = 1'b0;
    start_d = 1'b0;
    cplt_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise && is_tour) begin
          if (sq_ok) begin
            x_d     = cmd_UART[6:4];
            y_d     = cmd_UART[2:0];
            go_d    = 1'b1;
            timer_d = '0;
            state_d = SOLVE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SOLVE: begin
        timer_d = timer_q + TMO_W'(1);
        if (tour_done) begin
          state_d = START;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      START: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (send_resp) begin
          if (cnt_q == LAST_RESP) begin
            cplt_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      rdy_prev_q <= 1'b0;
      timer_q    <= '0;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      go_q       <= 1'b0;
      start_q    <= 1'b0;
      cplt_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= cmd_rdy_UART;
      rdy_prev_q <= rdy_q;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      go_q       <= go_d;
      start_q    <= start_d;
      cplt_q     <= cplt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign go         = go_q;
  assign x_start    = x_q;
  assign y_start    = y_q;
  assign start_tour = start_q;
  assign tour_busy  = busy_q;
  assign tour_cplt  = cplt_q;
  assign tour_err   = err_q;
  assign state_o    = state_q;

endmodule
